// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES inverse SubBytes: per-lane inverse affine, then x^254 over GF(2^8)
// computed in 7 square-and-multiply steps, with a valid/ready handshake on each side.
module inv_sub_bytes_iter #(
  parameter int unsigned NB = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*NB-1:0] state_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*NB-1:0] state_out
);

  typedef enum logic [1:0] {StIdle, StExp, StDone} state_e;

  // Shift-and-add multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    logic [7:0] m;
    r = 8'h00;
    x = a;
    m = b;
    for (int i = 0; i < 8; i++) begin
      if (m[0]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      m = m >> 1;
    end
    return r;
  endfunction

  // b[i] = s[i+2] ^ s[i+5] ^ s[i+7] ^ c[i] (indices mod 8), as right rotations.
  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[1:0], s[7:2]} ^ {s[4:0], s[7:5]} ^ {s[6:0], s[7]} ^ 8'h05;
  endfunction

  state_e     r_state;
  state_e     w_state_next;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_next;
  logic       w_load;
  logic       w_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_step       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_load       = 1'b1;
          w_cnt_next   = 3'd0;
          w_state_next = StExp;
        end
      end
      StExp: begin
        w_step     = 1'b1;
        w_cnt_next = r_cnt + 3'd1;
        if (r_cnt == 3'd6) w_state_next = StDone;
      end
      StDone: begin
        if (out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);

  for (genvar g = 0; g < NB; g++) begin : g_lane
    logic [7:0] r_p;
    logic [7:0] r_acc;
    logic [7:0] w_sq;

    assign w_sq = gf_mul(r_p, r_p);

    // acc collects p^2, p^4, ... p^128, i.e. a^254 = a^-1 after seven steps.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_p   <= 8'h00;
        r_acc <= 8'h00;
      end else if (w_load) begin
        r_p   <= inv_affine(state_in[8*g +: 8]);
        r_acc <= 8'h01;
      end else if (w_step) begin
        r_p   <= w_sq;
        r_acc <= gf_mul(r_acc, w_sq);
      end
    end

    assign state_out[8*g +: 8] = r_acc;
  end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Self-checking bench for inv_sub_bytes_iter: directed vector table, exhaustive lanes
// against a brute-force S-box model, back-pressure, reset mid-run and streaming.
module tb_inv_sub_bytes_iter;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sbox [256];
  logic [7:0] isbox[256];

  typedef struct {
    string        name;
    logic [127:0] din;
    logic [127:0] dexp;
  } vec_t;

  vec_t vecs[4];

  inv_sub_bytes_iter #(.NB(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .state_in (state_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    logic [7:0] m;
    r = 8'h00;
    x = a;
    m = b;
    for (int i = 0; i < 8; i++) begin
      if (m[0]) r = r ^ x;
      x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
      m = m >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] model_inv(input logic [127:0] din);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = isbox[din[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] model_fwd(input logic [127:0] din);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox[din[8*i +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Sends one block from IDLE, waits (bounded) for out_valid, then completes the handshake.
  task automatic do_block(input logic [127:0] din, output logic [127:0] dout, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    state_in = din;
    @(negedge clk);
    in_valid = 1'b0;
    state_in = ~din;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    dout = state_out;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] dout;
    logic [127:0] blk;
    logic [127:0] bexp;
    logic [127:0] sexp[10];
    int           lat;
    int           cnt;
    int           cyc;
    int           n_acc;
    int           n_out;
    int           last_acc;

    // Reference S-box: brute-force inverse plus forward affine; inverse table from that.
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);

    vecs[0] = '{"uniform_63", {16{8'h63}}, {16{8'h00}}};
    vecs[1] = '{"known_lanes", 128'h2B67_0130_C56F_6BF2_7B77_16FF_ED7C_6300,
                128'h0B0A_0908_0706_0504_0302_FF7D_5301_0052};
    vecs[2] = '{"uniform_00", {16{8'h00}}, {16{8'h52}}};
    vecs[3] = '{"uniform_7c", {16{8'h7C}}, {16{8'h01}}};

    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_state_out", state_out, 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      do_block(vecs[v].din, dout, lat);
      check({vecs[v].name, "_result"}, dout, vecs[v].dexp);
      check({vecs[v].name, "_latency"}, 128'(lat), 128'd7);
      check({vecs[v].name, "_post_out_valid"}, 128'(out_valid), 128'd0);
      check({vecs[v].name, "_post_in_ready"}, 128'(in_ready), 128'd1);
    end

    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(k * 16 + i);
      do_block(blk, dout, lat);
      check($sformatf("exhaustive_blk%0d", k), dout, model_inv(blk));
      check($sformatf("roundtrip_blk%0d", k), model_fwd(dout), blk);
    end

    // Back-pressure: result must hold while in_valid toggles and nothing new is taken.
    for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(i * 29 + 11);
    bexp = model_inv(blk);
    @(negedge clk);
    in_valid = 1'b1;
    state_in = blk;
    @(negedge clk);
    in_valid = 1'b0;
    state_in = '0;
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    for (int c = 0; c < 20; c++) begin
      check("bp_state_out", state_out, bexp);
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      in_valid = c[0];
      state_in = {4{$urandom()}};
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_out_valid", 128'(out_valid), 128'd0);
    check("bp_release_in_ready", 128'(in_ready), 128'd1);
    repeat (10) @(negedge clk);
    check("bp_no_extra_block", 128'(out_valid), 128'd0);

    // Reset in the middle of EXP discards the block.
    @(negedge clk);
    in_valid = 1'b1;
    state_in = {16{8'hA5}};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_state_out", state_out, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_output", 128'(out_valid), 128'd0);
    do_block(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, dout, lat);
    check("midrst_fresh_result", dout, model_inv(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210));
    check("midrst_fresh_latency", 128'(lat), 128'd7);

    // Streaming: in_valid and out_ready high, 10 blocks, one accept per 9 cycles.
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'((k * 16 + i) * 7 + 5);
      sexp[k] = model_inv(blk);
    end
    out_ready = 1'b1;
    cyc       = 0;
    n_acc     = 0;
    n_out     = 0;
    last_acc  = -1;
    while (n_out < 10 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        check($sformatf("stream_result%0d", n_out), state_out, sexp[n_out]);
        n_out++;
      end
      if (in_ready) begin
        if (n_acc < 10) begin
          if (last_acc >= 0) check("stream_spacing", 128'(cyc - last_acc), 128'd9);
          last_acc = cyc;
          for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'((n_acc * 16 + i) * 7 + 5);
          in_valid = 1'b1;
          state_in = blk;
          n_acc++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("stream_count", 128'(n_out), 128'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
